pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage pipeline; it is the producer of the stall and flush signals that every pipeline register consumes. It combines load-use hazard detection, branch-flush generation and a data-memory request FSM that freezes the whole pipeline while an off-core data memory access is outstanding. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and the data-memory interface.

## Interface
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data-memory data width
- REG_W, 5, register-index width
- TIMEOUT, 16, max BUSY cycles before abort (≥2)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- id_rs1_i, id_rs2_i  in  REG_W  source registers of the instruction in ID
- ex_rd_i  in  REG_W  destination register of the instruction in EX
- ex_memread_i  in  1  EX instruction is a load
- branch_taken_i  in  1  ID resolved a taken branch
- mem_req_i  in  1  MEM-stage instruction needs data memory
- mem_we_i  in  1  MEM access is a store
- mem_addr_i  in  ADDR_W  MEM access address
- mem_wdata_i  in  DATA_W  MEM store data
- dmem_req_o  out  1  request to data memory
- dmem_we_o  out  1  registered write enable
- dmem_addr_o  out  ADDR_W  registered address
- dmem_wdata_o  out  DATA_W  registered store data
- dmem_ack_i  in  1  memory completion (one-cycle pulse)
- dmem_rdata_i  in  DATA_W  read data, valid with ack
- mem_rdata_o  out  DATA_W  captured load data to MEM/WB
- freeze_o  out  1  hold every pipeline register and PC
- pc_hold_o, if_id_hold_o  out  1  hold PC and IF/ID (load-use or freeze)
- id_ex_bubble_o  out  1  drive stall_i of ID/EX (insert bubble)
- if_id_flush_o  out  1  drive flush_i of IF/ID
- err_o  out  1  sticky memory-timeout flag
- stall_cnt_o  out  32  stall-cycle performance counter

## Operation
- FSM states IDLE, BUSY, DONE.
- IDLE: mem_req_i=1 → latch mem_we_i/mem_addr_i/mem_wdata_i into dmem_* registers, clear timeout counter, go BUSY.
- BUSY: dmem_req_o=1; counter increments each cycle. dmem_ack_i=1 → capture dmem_rdata_i (loads only; stores leave mem_rdata_o unchanged), go DONE. Counter reaching TIMEOUT-1 without ack → mem_rdata_o=0, err_o set, go DONE. Ack on the same cycle as the timeout: ack wins, err_o not set.
- DONE: freeze released for exactly one cycle so the MEM instruction advances; unconditionally return to IDLE (a new mem_req_i is seen there the following cycle).
- freeze_o = (IDLE & mem_req_i) | BUSY; combinational so the requesting instruction never leaves MEM.
- Load-use: lu = ex_memread_i & ex_rd_i≠0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
- Priority: freeze > load-use > flush. freeze_o=1 → pc_hold_o=if_id_hold_o=1, id_ex_bubble_o=0, if_id_flush_o=0. Else lu → holds=1, id_ex_bubble_o=1, if_id_flush_o=0 (branch resolved on stale operand is ignored). Else if_id_flush_o=branch_taken_i, others 0.
- stall_cnt_o increments by 1 each cycle freeze_o|lu; wraps modulo 2^32.
- err_o clears only on reset.

## Timing
- Reset (rst_i=0 at an edge): state IDLE, dmem_* registers 0, mem_rdata_o 0, err_o 0, stall_cnt_o 0; combinational outputs follow from IDLE. Reset during BUSY aborts: dmem_req_o low in the cycle after the edge.
- dmem_req_o rises 1 cycle after mem_req_i is first seen in IDLE; dmem_* stable for all BUSY cycles.
- Minimum memory access: request cycle (IDLE) + 1 BUSY cycle with ack + DONE = 3 cycles, freeze high for the first 2.
- Ack while not BUSY is ignored.
- mem_rdata_o valid from the DONE cycle until the next captured load.

## Structure
- Shared package: state enum {IDLE, BUSY, DONE}, counter width derived from TIMEOUT, REG_W default.
- Sub-module load_use_detect: purely combinational lu comparator; everything else in the top.

## Test plan
- Reset then idle: all outputs 0, stall_cnt_o=0; branch_taken_i=1 → if_id_flush_o=1 same cycle.
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, branch_taken_i=1 → pc_hold_o=if_id_hold_o=id_ex_bubble_o=1, if_id_flush_o=0; ex_rd_i=0 → no stall.
- Load, ack after 3 BUSY cycles, dmem_rdata_i=0xDEADBEEF → freeze_o high 4 cycles, dmem_addr_o=mem_addr_i throughout, mem_rdata_o=0xDEADBEEF in DONE, stall_cnt_o=4.
- Store never acked, TIMEOUT=16 → 16 BUSY cycles, err_o=1 sticky, mem_rdata_o=0, return to IDLE.
- Back-to-back loads with mem_req_i held across DONE → second dmem_req_o starts 2 cycles after first ack; rst_i=0 mid-BUSY → IDLE, dmem_req_o=0 next cycle.
- stall_cnt_o preloaded near 0xFFFFFFFF via forced stalls → wraps to 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline stall/flush controller.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mem_state_e;

  localparam int unsigned RegWDefault    = 5;
  localparam int unsigned TimeoutDefault = 16;

  // Width of the BUSY-cycle counter; it only needs to reach timeout-1.
  function automatic int unsigned timeout_cnt_w(int unsigned timeout);
    int unsigned w;
    w = unsigned'($clog2(timeout));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Data-memory request/response bus between the stall controller and off-core memory.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = RegWDefault
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  output logic             lu_o
);

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_o = ex_memread_i && (ex_rd_i != '0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: load-use stalls, branch flushes and a data-memory
// request FSM that freezes the whole pipeline while an access is outstanding.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = RegWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_W-1:0]      id_rs1_i,
  input  logic [REG_W-1:0]      id_rs2_i,
  input  logic [REG_W-1:0]      ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  pipeline_stall_ctrl_if.master dmem,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  freeze_o,
  output logic                  pc_hold_o,
  output logic                  if_id_hold_o,
  output logic                  id_ex_bubble_o,
  output logic                  if_id_flush_o,
  output logic                  err_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int unsigned    CntW    = timeout_cnt_w(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic busy;
  logic lu;
  logic timeout_hit;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .ex_memread_i(ex_memread_i),
    .ex_rd_i     (ex_rd_i),
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .lu_o        (lu)
  );

  // An ack in the final BUSY cycle takes precedence over the timeout.
  assign timeout_hit = (state_q == StBusy) && !dmem.ack && (cnt_q == CntLast);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_req_i) state_d = StBusy;
      StBusy: if (dmem.ack || timeout_hit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; freeze asserts in the request cycle so the MEM instruction never leaves.
  always_comb begin
    freeze = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      StIdle: freeze = mem_req_i;
      StBusy: begin
        freeze = 1'b1;
        busy   = 1'b1;
      end
      StDone: freeze = 1'b0;
      default: freeze = 1'b0;
    endcase
  end

  // Hold/bubble/flush arbitration: freeze > load-use > branch flush.
  always_comb begin
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    if (freeze) begin
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
    end else if (lu) begin
      pc_hold_o      = 1'b1;
      if_id_hold_o   = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else begin
      if_id_flush_o = branch_taken_i;
    end
  end

  // Request latch, timeout counter, load capture, error flag and stall counter.
  always_comb begin
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q + {31'b0, (freeze | lu)};
    if ((state_q == StIdle) && mem_req_i) begin
      we_d    = mem_we_i;
      addr_d  = mem_addr_i;
      wdata_d = mem_wdata_i;
      cnt_d   = '0;
    end else if (state_q == StBusy) begin
      if (dmem.ack) begin
        if (!we_q) rdata_d = dmem.rdata;
      end else if (timeout_hit) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem.req    = busy;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.wdata  = wdata_q;
  assign mem_rdata_o = rdata_q;
  assign freeze_o    = freeze;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized bench for pipeline_stall_ctrl against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, ex_rd = '0;
  logic        ex_memread = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata, stall_cnt;
  logic        freeze, pc_hold, if_id_hold, bubble, flush, err;

  pipeline_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

  pipeline_stall_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .REG_W  (5),
    .TIMEOUT(Timeout)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .ex_rd_i       (ex_rd),
    .ex_memread_i  (ex_memread),
    .branch_taken_i(branch_taken),
    .mem_req_i     (mem_req),
    .mem_we_i      (mem_we),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .dmem          (dmem_bus),
    .mem_rdata_o   (mem_rdata),
    .freeze_o      (freeze),
    .pc_hold_o     (pc_hold),
    .if_id_hold_o  (if_id_hold),
    .id_ex_bubble_o(bubble),
    .if_id_flush_o (flush),
    .err_o         (err),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Behavioural model: an access is either outstanding (with its age), just finished, or absent.
  bit          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int          m_age  = 0;
  logic        m_we   = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_cnt = '0;

  int frz_seen = 0;
  int req_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic bit exp_lu();
    return ex_memread && (ex_rd != 0) && ((ex_rd == rs1) || (ex_rd == rs2));
  endfunction

  function automatic bit exp_freeze();
    return m_busy || (!m_done && mem_req);
  endfunction

  task automatic compare_all();
    bit f, l;
    f = exp_freeze();
    l = exp_lu();
    check_eq("freeze", 64'(freeze), 64'(f));
    check_eq("pc_hold", 64'(pc_hold), 64'(f || l));
    check_eq("if_id_hold", 64'(if_id_hold), 64'(f || l));
    check_eq("bubble", 64'(bubble), 64'(!f && l));
    check_eq("flush", 64'(flush), 64'(!f && !l && branch_taken));
    check_eq("dmem_req", 64'(dmem_bus.req), 64'(m_busy));
    check_eq("dmem_we", 64'(dmem_bus.we), 64'(m_we));
    check_eq("dmem_addr", 64'(dmem_bus.addr), 64'(m_addr));
    check_eq("dmem_wdata", 64'(dmem_bus.wdata), 64'(m_wdata));
    check_eq("mem_rdata", 64'(mem_rdata), 64'(m_rdata));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic model_update();
    bit stall_now;
    stall_now = exp_freeze() || exp_lu();
    if (!rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_age = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = '0;
      return;
    end
    if (m_busy) begin
      if (dmem_bus.ack) begin
        if (!m_we) m_rdata = dmem_bus.rdata;
        m_busy = 0;
        m_done = 1;
      end else if (m_age == int'(Timeout) - 1) begin
        m_rdata = '0;
        m_err   = 1;
        m_busy  = 0;
        m_done  = 1;
      end else begin
        m_age++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (mem_req) begin
      m_busy  = 1;
      m_age   = 0;
      m_we    = mem_we;
      m_addr  = mem_addr;
      m_wdata = mem_wdata;
    end
    m_cnt = m_cnt + (stall_now ? 32'd1 : 32'd0);
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic step(input bit chk);
    #1;
    if (chk) compare_all();
    if (freeze) frz_seen++;
    if (dmem_bus.req) req_seen++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; ex_rd = '0; ex_memread = 0; branch_taken = 0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    dmem_bus.ack = 0; dmem_bus.rdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    step(0);
    step(1);
    rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_step;
    int rise_at[$];
    bit prev_req;
    int ack_pct;

    idle_inputs();
    @(negedge clk);
    do_reset();
    #1;
    check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_rdata", 64'(mem_rdata), 64'd0);
    check_eq("rst_dmem_req", 64'(dmem_bus.req), 64'd0);
    check_eq("rst_freeze", 64'(freeze), 64'd0);
    step(1);

    // Branch flush while idle, then load-use suppressing it, then x0 destination.
    branch_taken = 1;
    #1 check_eq("idle_flush", 64'(flush), 64'd1);
    step(1);
    ex_memread = 1; ex_rd = 5; rs1 = 1; rs2 = 5;
    #1;
    check_eq("lu_pc_hold", 64'(pc_hold), 64'd1);
    check_eq("lu_if_id_hold", 64'(if_id_hold), 64'd1);
    check_eq("lu_bubble", 64'(bubble), 64'd1);
    check_eq("lu_flush", 64'(flush), 64'd0);
    step(1);
    ex_rd = 0; rs2 = 0;
    #1;
    check_eq("x0_bubble", 64'(bubble), 64'd0);
    check_eq("x0_hold", 64'(pc_hold), 64'd0);
    step(1);

    // Load acked in the third BUSY cycle.
    do_reset();
    frz_seen = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h1000_0040; mem_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      dmem_bus.ack   = (i == 3);
      dmem_bus.rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
      step(1);
      if (i < 3) check_eq("load_addr_busy", 64'(dmem_bus.addr), 64'h1000_0040);
    end
    mem_req = 0; dmem_bus.ack = 0;
    check_eq("load_rdata_done", 64'(mem_rdata), 64'hDEAD_BEEF);
    check_eq("load_stall_cnt", 64'(stall_cnt), 64'd4);
    check_eq("load_freeze_cycles", 64'(frz_seen), 64'd4);
    step(1);

    // Store never acked: times out after TIMEOUT BUSY cycles and clears the load data.
    req_seen = 0;
    mem_we = 1; mem_addr = 32'h2000_0000; mem_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 24; i++) begin
      mem_req = (i <= int'(Timeout));
      step(1);
    end
    check_eq("to_busy_cycles", 64'(req_seen), 64'(Timeout));
    check_eq("to_err", 64'(err), 64'd1);
    check_eq("to_rdata", 64'(mem_rdata), 64'd0);
    check_eq("to_idle_freeze", 64'(freeze), 64'd0);
    mem_we = 0;

    // Back-to-back loads with mem_req held: second request begins two edges after the ack edge.
    rise_at.delete();
    prev_req = 0;
    ack_step = -1;
    mem_req = 1; mem_addr = 32'h3000_0008;
    for (int i = 0; i < 8; i++) begin
      if (dmem_bus.req && !prev_req) rise_at.push_back(i);
      prev_req = dmem_bus.req;
      dmem_bus.ack   = m_busy;
      dmem_bus.rdata = 32'h1234_0000 + 32'(i);
      if (m_busy && ack_step < 0) ack_step = i;
      step(1);
    end
    check_eq("b2b_rises", 64'(rise_at.size()), 64'd3);
    if (rise_at.size() >= 2) check_eq("b2b_gap", 64'(rise_at[1] - ack_step), 64'd3);
    dmem_bus.ack = 0;

    // Reset in the middle of a BUSY period aborts the access.
    mem_req = 0;
    step(1);
    step(1);
    mem_req = 1;
    step(1);
    step(1);
    rst = 0;
    step(1);
    rst = 1; mem_req = 0;
    check_eq("rst_busy_req", 64'(dmem_bus.req), 64'd0);
    check_eq("rst_busy_err", 64'(err), 64'd0);
    step(1);

    // Stall counter wrap from a preloaded value.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    ex_memread = 1; ex_rd = 3; rs1 = 3; rs2 = 0;
    step(1);
    step(1);
    check_eq("wrap_zero", 64'(stall_cnt), 64'd0);
    step(1);
    check_eq("wrap_one", 64'(stall_cnt), 64'd1);
    idle_inputs();
    step(1);

    // Randomized traffic, including acks outside BUSY and occasional resets.
    ack_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 10;
          default: ack_pct = 50;
        endcase
      end
      rst            = ($urandom_range(0, 299) != 0);
      rs1            = 5'($urandom_range(0, 3));
      rs2            = 5'($urandom_range(0, 3));
      ex_rd          = 5'($urandom_range(0, 3));
      ex_memread     = $urandom_range(0, 1) != 0;
      branch_taken   = $urandom_range(0, 2) == 0;
      mem_req        = $urandom_range(0, 1) != 0;
      mem_we         = $urandom_range(0, 1) != 0;
      mem_addr       = $urandom;
      mem_wdata      = $urandom;
      dmem_bus.ack   = $urandom_range(0, 99) < ack_pct;
      dmem_bus.rdata = $urandom;
      step(1);
    end
    rst = 1;
    idle_inputs();
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
